// File: rtl/text_overlay_pkg.sv
// Shared window geometry, glyph codes, colour defaults and glyph ROM contents.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package text_overlay_pkg;

    localparam int WIN_CELLS = 8;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;
    localparam int WIN_W     = WIN_CELLS * CELL_W;
    localparam int WIN_H     = CELL_H;

    localparam int          X0_DEF = 64;
    localparam int          Y0_DEF = 32;
    localparam logic [11:0] FG_DEF = 12'hFFF;
    localparam logic [11:0] BG_DEF = 12'h000;

    typedef enum logic [1:0] {
        GLYPH_BLANK = 2'd0,
        GLYPH_F     = 2'd1,
        GLYPH_H     = 2'd2,
        GLYPH_RSVD  = 2'd3
    } glyph_e;

    // Glyph ROM row lookup, MSB is the leftmost pixel. Rows 0-1 and 14-15
    // are empty so glyphs sit centred in their 16-row cell.
    function automatic logic [7:0] glyph_row(input logic [1:0] code,
                                             input logic [3:0] row);
        logic [7:0] r;
        r = 8'h00;
        case (code)
            2'(GLYPH_F): begin
                if (row == 4'd2 || row == 4'd3)      r = 8'hFE;
                else if (row == 4'd7 || row == 4'd8) r = 8'hFC;
                else if (row >= 4'd4 && row <= 4'd13) r = 8'hC0;
            end
            2'(GLYPH_H): begin
                if (row == 4'd7 || row == 4'd8)      r = 8'hFE;
                else if (row >= 4'd2 && row <= 4'd13) r = 8'hC6;
            end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/text_overlay_if.sv
// Pixel stream, character-buffer write port, glyph ROM port and colour output.
// Latency: n/a (wiring only).
// Backpressure: none; pixel_tick is a pure enable, the overlay never stalls.
interface text_overlay_if;
    import text_overlay_pkg::*;

    logic        pixel_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [1:0]  wr_char;
    logic [7:0]  blink_sel;
    logic [5:0]  font_addr;
    logic [7:0]  font_data;
    logic [11:0] rgb;
    logic        text_on;

    // master: video timing / CPU / glyph ROM side
    modport master (
        output pixel_tick, video_on, pixel_x, pixel_y,
        output wr_en, wr_idx, wr_char, blink_sel, font_data,
        input  font_addr, rgb, text_on
    );

    // slave: the overlay itself
    modport slave (
        input  pixel_tick, video_on, pixel_x, pixel_y,
        input  wr_en, wr_idx, wr_char, blink_sel, font_data,
        output font_addr, rgb, text_on
    );

endinterface

// File: rtl/text_overlay_blink_timer.sv
// Frame counter for glyph blinking; phase is the counter MSB (16 on, 16 off).
// Latency: phase updates the clk after a frame_tick.
// Backpressure: none; counts only on frame_tick.
// Ports: clk, reset_n (sync, active-low), frame_tick in, phase out.
module blink_timer (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    output logic phase
);
    logic [4:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) frame_cnt_d = frame_cnt_q + 5'd1;   // wraps 31 -> 0
    end

    always_ff @(posedge clk) begin
        if (!reset_n) frame_cnt_q <= 5'd0;
        else          frame_cnt_q <= frame_cnt_d;
    end

    assign phase = frame_cnt_q[4];

endmodule

// File: rtl/text_overlay.sv
// 8-cell 8x16 text window overlay with per-slot blink, fed by an external glyph ROM.
// Latency: 2 pixel_ticks from pixel coordinate to rgb/text_on; font_addr after 1.
// Backpressure: none; pipeline holds when pixel_tick is low, buffer writes any clk.
// Ports: clk, reset_n (sync, active-low), bus (text_overlay_if.slave).
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int          X0 = X0_DEF,
    parameter int          Y0 = Y0_DEF,
    parameter logic [11:0] FG = FG_DEF,
    parameter logic [11:0] BG = BG_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    text_overlay_if.slave bus
);
    localparam logic [10:0] X0_L = 11'(X0);
    localparam logic [10:0] Y0_L = 11'(Y0);
    localparam logic [10:0] X1_L = 11'(X0 + WIN_W);
    localparam logic [10:0] Y1_L = 11'(Y0 + WIN_H);

    // Character buffer
    logic [7:0][1:0] cbuf_q, cbuf_d;

    // Stage 1
    logic [5:0] font_addr_q, font_addr_d;
    logic [2:0] col_q, col_d;
    logic       in_win1_q, in_win1_d;
    logic       von1_q, von1_d;
    logic       hide1_q, hide1_d;

    // Stage 2
    logic       bit2_q, bit2_d;
    logic       in_win2_q, in_win2_d;
    logic       von2_q, von2_d;
    logic       hide2_q, hide2_d;

    logic       phase;
    logic       frame_tick;
    logic       in_win;
    logic [5:0] dx;
    logic [3:0] dy;
    logic [2:0] slot;
    logic [1:0] code;

    assign frame_tick = bus.pixel_tick && (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);

    blink_timer u_blink_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .phase      (phase)
    );

    // Only the low bits of the offsets are needed; modular subtraction on the
    // truncated operands gives the same low bits as the full-width difference.
    assign dx = bus.pixel_x[5:0] - X0_L[5:0];
    assign dy = bus.pixel_y[3:0] - Y0_L[3:0];

    always_comb begin
        in_win = ({1'b0, bus.pixel_x} >= X0_L) && ({1'b0, bus.pixel_x} < X1_L) &&
                 ({1'b0, bus.pixel_y} >= Y0_L) && ({1'b0, bus.pixel_y} < Y1_L);
        slot   = dx[5:3];
        code   = cbuf_q[slot];          // pre-write value: same-cycle write is not seen
        if (code == 2'(GLYPH_RSVD)) code = 2'(GLYPH_BLANK);
    end

    always_comb begin
        cbuf_d = cbuf_q;
        if (bus.wr_en) cbuf_d[bus.wr_idx] = bus.wr_char;
    end

    always_comb begin
        font_addr_d = font_addr_q;
        col_d       = col_q;
        in_win1_d   = in_win1_q;
        von1_d      = von1_q;
        hide1_d     = hide1_q;
        bit2_d      = bit2_q;
        in_win2_d   = in_win2_q;
        von2_d      = von2_q;
        hide2_d     = hide2_q;
        if (bus.pixel_tick) begin
            font_addr_d = in_win ? {code, dy} : 6'h00;
            col_d       = dx[2:0];
            in_win1_d   = in_win;
            von1_d      = bus.video_on;
            hide1_d     = in_win && bus.blink_sel[slot] && phase;
            // font_data answers font_addr_q combinationally, so it pairs with col_q
            bit2_d      = bus.font_data[3'd7 - col_q];
            in_win2_d   = in_win1_q;
            von2_d      = von1_q;
            hide2_d     = hide1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cbuf_q      <= '0;
            font_addr_q <= 6'h00;
            col_q       <= 3'd0;
            in_win1_q   <= 1'b0;
            von1_q      <= 1'b0;
            hide1_q     <= 1'b0;
            bit2_q      <= 1'b0;
            in_win2_q   <= 1'b0;
            von2_q      <= 1'b0;
            hide2_q     <= 1'b0;
        end else begin
            cbuf_q      <= cbuf_d;
            font_addr_q <= font_addr_d;
            col_q       <= col_d;
            in_win1_q   <= in_win1_d;
            von1_q      <= von1_d;
            hide1_q     <= hide1_d;
            bit2_q      <= bit2_d;
            in_win2_q   <= in_win2_d;
            von2_q      <= von2_d;
            hide2_q     <= hide2_d;
        end
    end

    assign bus.font_addr = font_addr_q;
    assign bus.text_on   = von2_q && in_win2_q;
    assign bus.rgb       = (von2_q && in_win2_q) ? ((bit2_q && !hide2_q) ? FG : BG) : 12'h000;

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay with a behavioural glyph ROM on font_addr/font_data.
// Latency: checks font_addr one pixel_tick and rgb/text_on two pixel_ticks after a pixel.
// Backpressure: n/a; stimulus changes on the falling edge, outputs sampled there too.
module tb_text_overlay;
    import text_overlay_pkg::*;

    localparam logic [9:0] X0 = 10'd64;
    localparam logic [9:0] Y0 = 10'd32;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    text_overlay_if bus ();

    text_overlay dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.font_data = glyph_row(bus.font_addr[5:4], bus.font_addr[3:0]);

    // One pixel with pixel_tick high across one rising edge; ends on a falling edge.
    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic von);
        bus.pixel_x    = x;
        bus.pixel_y    = y;
        bus.video_on   = von;
        bus.pixel_tick = 1'b1;
        @(negedge clk);
        bus.pixel_tick = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [1:0] ch);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = idx;
        bus.wr_char = ch;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.pixel_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.font_addr !== 6'h00) begin errors++; $display("FAIL reset_font_addr got %h exp 00", bus.font_addr); end
        checks++;
        if (bus.rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", bus.rgb); end
        checks++;
        if (bus.text_on !== 1'b0) begin errors++; $display("FAIL reset_text_on got %b exp 0", bus.text_on); end
    endtask

    // 'F' in slot 0, row 2 (8'hFE)
    task automatic test_basic();
        wr(3'd0, 2'd1);
        px(X0, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.font_addr !== 6'h12) begin errors++; $display("FAIL basic_font_addr got %h exp 12", bus.font_addr); end
        checks++;
        if (bus.text_on !== 1'b0) begin errors++; $display("FAIL basic_text_on_1tick got %b exp 0", bus.text_on); end
        px(X0 + 10'd7, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'hFFF || bus.text_on !== 1'b1) begin
            errors++; $display("FAIL basic_fg got rgb %h on %b exp FFF 1", bus.rgb, bus.text_on);
        end
        px(X0 + 10'd8, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'h000 || bus.text_on !== 1'b1) begin
            errors++; $display("FAIL basic_col7_bg got rgb %h on %b exp 000 1", bus.rgb, bus.text_on);
        end
    endtask

    // 'H' in slot 1 and window edges
    task automatic test_cell_edges();
        wr(3'd1, 2'd2);
        px(X0 + 10'd8, Y0 + 10'd6, 1'b1);
        checks++;
        if (bus.font_addr !== 6'h26) begin errors++; $display("FAIL h_font_addr got %h exp 26", bus.font_addr); end
        px(X0 + 10'd64, Y0, 1'b1);
        checks++;
        if (bus.font_addr !== 6'h00) begin errors++; $display("FAIL right_edge_font_addr got %h exp 00", bus.font_addr); end
        checks++;
        if (bus.rgb !== 12'hFFF || bus.text_on !== 1'b1) begin
            errors++; $display("FAIL h_fg got rgb %h on %b exp FFF 1", bus.rgb, bus.text_on);
        end
        px(X0 - 10'd1, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.text_on !== 1'b0 || bus.rgb !== 12'h000) begin
            errors++; $display("FAIL right_edge_off got rgb %h on %b exp 000 0", bus.rgb, bus.text_on);
        end
        px(X0 + 10'd1, Y0 + 10'd16, 1'b1);
        checks++;
        if (bus.text_on !== 1'b0) begin errors++; $display("FAIL left_edge_off got %b exp 0", bus.text_on); end
        px(X0 + 10'd9, Y0 + 10'd15, 1'b1);
        checks++;
        if (bus.text_on !== 1'b0) begin errors++; $display("FAIL bottom_edge_off got %b exp 0", bus.text_on); end
        checks++;
        if (bus.font_addr !== 6'h2F) begin errors++; $display("FAIL last_row_font_addr got %h exp 2F", bus.font_addr); end
        px(X0, Y0 + 10'd2, 1'b0);
        checks++;
        if (bus.text_on !== 1'b1) begin errors++; $display("FAIL last_row_on got %b exp 1", bus.text_on); end
        px(X0, Y0 + 10'd2, 1'b0);
        checks++;
        if (bus.text_on !== 1'b0 || bus.rgb !== 12'h000) begin
            errors++; $display("FAIL video_off got rgb %h on %b exp 000 0", bus.rgb, bus.text_on);
        end
    endtask

    // Reserved code 3 renders as blank
    task automatic test_reserved();
        wr(3'd2, 2'd3);
        px(X0 + 10'd16, Y0 + 10'd4, 1'b1);
        checks++;
        if (bus.font_addr !== 6'h04) begin errors++; $display("FAIL rsvd_font_addr got %h exp 04", bus.font_addr); end
        px(X0 + 10'd17, Y0 + 10'd4, 1'b1);
        checks++;
        if (bus.rgb !== 12'h000 || bus.text_on !== 1'b1) begin
            errors++; $display("FAIL rsvd_bg got rgb %h on %b exp 000 1", bus.rgb, bus.text_on);
        end
    endtask

    // Nothing moves while pixel_tick is low
    task automatic test_stall();
        px(X0, Y0 + 10'd2, 1'b1);
        px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        bus.pixel_x  = 10'd0;
        bus.pixel_y  = 10'd0;
        bus.video_on = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.rgb !== 12'hFFF || bus.text_on !== 1'b1 || bus.font_addr !== 6'h12) begin
            errors++; $display("FAIL stall_hold got rgb %h on %b addr %h exp FFF 1 12", bus.rgb, bus.text_on, bus.font_addr);
        end
    endtask

    // Same-edge write and read of slot 0: old code wins, new code next pixel
    task automatic test_collision();
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 3'd0;
        bus.wr_char = 2'd2;
        px(X0, Y0 + 10'd6, 1'b1);
        bus.wr_en = 1'b0;
        checks++;
        if (bus.font_addr !== 6'h16) begin errors++; $display("FAIL collide_old got %h exp 16", bus.font_addr); end
        px(X0 + 10'd1, Y0 + 10'd6, 1'b1);
        checks++;
        if (bus.font_addr !== 6'h26) begin errors++; $display("FAIL collide_new got %h exp 26", bus.font_addr); end
    endtask

    task automatic test_blink();
        do_reset();
        wr(3'd0, 2'd1);
        wr(3'd1, 2'd2);
        bus.blink_sel = 8'h01;
        px(X0, Y0 + 10'd2, 1'b1); px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'hFFF) begin errors++; $display("FAIL blink_f0 got %h exp FFF", bus.rgb); end
        for (int i = 0; i < 15; i++) px(10'd0, 10'd0, 1'b0);
        px(X0, Y0 + 10'd2, 1'b1); px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'hFFF) begin errors++; $display("FAIL blink_f15 got %h exp FFF", bus.rgb); end
        px(10'd0, 10'd0, 1'b0);
        px(X0, Y0 + 10'd2, 1'b1); px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'h000 || bus.text_on !== 1'b1) begin
            errors++; $display("FAIL blink_f16 got rgb %h on %b exp 000 1", bus.rgb, bus.text_on);
        end
        px(X0 + 10'd8, Y0 + 10'd6, 1'b1); px(X0 + 10'd9, Y0 + 10'd6, 1'b1);
        checks++;
        if (bus.rgb !== 12'hFFF) begin errors++; $display("FAIL blink_other_slot got %h exp FFF", bus.rgb); end
        for (int i = 0; i < 15; i++) px(10'd0, 10'd0, 1'b0);
        px(X0, Y0 + 10'd2, 1'b1); px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'h000) begin errors++; $display("FAIL blink_f31 got %h exp 000", bus.rgb); end
        px(10'd0, 10'd0, 1'b0);
        px(X0, Y0 + 10'd2, 1'b1); px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'hFFF) begin errors++; $display("FAIL blink_wrap got %h exp FFF", bus.rgb); end
        bus.blink_sel = 8'h00;
    endtask

    task automatic test_reset_mid();
        px(X0, Y0 + 10'd2, 1'b1); px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        bus.pixel_x    = X0 + 10'd2;
        bus.pixel_tick = 1'b1;
        reset_n        = 1'b0;
        @(negedge clk);
        bus.pixel_tick = 1'b0;
        reset_n        = 1'b1;
        checks++;
        if (bus.rgb !== 12'h000 || bus.text_on !== 1'b0 || bus.font_addr !== 6'h00) begin
            errors++; $display("FAIL mid_reset got rgb %h on %b addr %h exp 000 0 00", bus.rgb, bus.text_on, bus.font_addr);
        end
        px(X0, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.font_addr !== 6'h02 || bus.text_on !== 1'b0) begin
            errors++; $display("FAIL post_reset_1tick got addr %h on %b exp 02 0", bus.font_addr, bus.text_on);
        end
        px(X0 + 10'd1, Y0 + 10'd2, 1'b1);
        checks++;
        if (bus.rgb !== 12'h000 || bus.text_on !== 1'b1) begin
            errors++; $display("FAIL post_reset_blank got rgb %h on %b exp 000 1", bus.rgb, bus.text_on);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.pixel_tick = 1'b0;
        bus.video_on   = 1'b0;
        bus.pixel_x    = 10'd0;
        bus.pixel_y    = 10'd0;
        bus.wr_en      = 1'b0;
        bus.wr_idx     = 3'd0;
        bus.wr_char    = 2'd0;
        bus.blink_sel  = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_cell_edges();
        test_reserved();
        test_stall();
        test_collision();
        test_blink();
        wr(3'd0, 2'd1);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 SHALL have parameter X0, default 64, meaning left pixel column of the text window.
REQ-002 SHALL have parameter Y0, default 32, meaning top pixel row of the text window.
REQ-003 SHALL have parameter FG, default 12'hFFF, meaning glyph foreground colour.
REQ-004 SHALL have parameter BG, default 12'h000, meaning window background colour.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 pixel_tick  in  1  pixel enable, one clk cycle per pixel.
REQ-008 video_on  in  1  visible-area flag from the VGA sync generator.
REQ-009 pixel_x  in  10  current pixel column.
REQ-010 pixel_y  in  10  current pixel row.
REQ-011 wr_en  in  1  character-buffer write strobe.
REQ-012 wr_idx  in  3  character slot to write, 0..7.
REQ-013 wr_char  in  2  glyph code: 0 blank, 1 'F', 2 'H', 3 reserved/blank.
REQ-014 blink_sel  in  8  per-slot blink enable.
REQ-015 font_addr  out  6  glyph ROM address {code[1:0], row[3:0]}.
REQ-016 font_data  in  8  glyph ROM row, combinational response to font_addr, MSB = leftmost pixel.
REQ-017 rgb  out  12  pixel colour.
REQ-018 text_on  out  1  pixel lies inside the text window.

Function
REQ-019 Window SHALL be 8 cells of 8x16 pixels: X0 <= pixel_x < X0+64, Y0 <= pixel_y < Y0+16.
REQ-020 Character buffer SHALL be 8 x 2-bit registers, written on any clk edge with wr_en=1, independent of pixel_tick.
REQ-021 Stage 1, on pixel_tick: register font_addr = {buf[(pixel_x-X0)>>3], (pixel_y-Y0)[3:0]}, column = (pixel_x-X0)[2:0], in_window, video_on, blink_hide for that slot.
REQ-022 Outside the window stage 1 SHALL register font_addr = 6'h00.
REQ-023 Stage 2, on pixel_tick: register pixel_bit = font_data[7-column] and all delayed flags.
REQ-024 Output: rgb = FG if video_on_d2 & in_window_d2 & pixel_bit & ~hide_d2; BG if video_on_d2 & in_window_d2 otherwise; 12'h000 else.
REQ-025 text_on SHALL equal video_on_d2 & in_window_d2.
REQ-026 Latency from pixel coordinate to rgb/text_on SHALL be exactly 2 pixel_ticks; no state advances without pixel_tick.
REQ-027 Frame counter, 5 bits, SHALL increment on pixel_tick with pixel_x=0 and pixel_y=0, wrapping 31->0.
REQ-028 blink_hide SHALL be blink_sel[slot] & frame_cnt[4] (16 frames shown, 16 hidden).
REQ-029 Write and stage-1 read of the same slot in one cycle: read SHALL see the old value; new value visible from the next cycle.
REQ-030 Code 3 SHALL be forced to blank by presenting code 0 on font_addr.

Reset
REQ-031 With reset_n=0 at a clk edge: buffer slots, frame counter and all pipeline registers SHALL clear to 0; rgb=12'h000, text_on=0, font_addr=6'h00 the following cycle.
REQ-032 Reset asserted mid-frame SHALL abort the pipeline; first valid rgb two pixel_ticks after reset_n returns to 1.

Structure
REQ-033 Window geometry constants, glyph codes and colour defaults SHALL live in a shared package, also used by the glyph ROM.
REQ-034 Frame/blink counter SHALL be a sub-module blink_timer (clk, reset_n, frame_tick -> phase).

Verification
REQ-035 buf[0]=1, pixel (X0, Y0+2) -> font_addr 6'h12 after 1 tick; rgb 12'hFFF, text_on=1 after 2 ticks.
REQ-036 buf[0]=1, pixel (X0+7, Y0+2) -> font_data 8'hFE bit0=0 -> rgb 12'h000 (BG), text_on=1.
REQ-037 buf[1]=2, pixel (X0+8, Y0+6) -> font_addr 6'h26, rgb FG; pixel (X0+64, Y0) -> text_on=0, font_addr 6'h00.
REQ-038 blink_sel=8'h01, buf[0]=1: frames 0-15 show 'F', frames 16-31 rgb BG at glyph pixels, frame 32 shows again (wrap).
REQ-039 wr_en to slot 0 in same cycle stage 1 reads slot 0 -> old code used, new code on next pixel.
REQ-040 reset_n=0 mid-window -> next cycle rgb=0, text_on=0, buffer reads blank afterwards.
